// File: rtl/piso_tx_if.sv
// Load handshake and serial output bundle for piso_tx.
// The transmitter uses the slave modport. The producer/line side uses the master modport.
interface piso_tx_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             busy;

  modport master (
    output din, load_valid,
    input  load_ready, sout, sout_valid, sout_last, busy
  );

  modport slave (
    input  din, load_valid,
    output load_ready, sout, sout_valid, sout_last, busy
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter. It sends one frame bit per clock, LSB first.
// Optional even parity bit after the data bits when PISO_TX_PARITY_EN is defined.
module piso_tx #(
  parameter int unsigned WIDTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  piso_tx_if.slave bus
);

`ifdef PISO_TX_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif
  localparam int unsigned   CW       = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] PRE_IDX  = CW'(FRAME_LEN - 2);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             final_bit;
  logic             accept;
`ifdef PISO_TX_PARITY_EN
  logic             par;
`endif

  // The final-bit cycle reopens the load window, so frames can run back to back.
  assign final_bit      = (state == SHIFT) && (cnt == LAST_IDX);
  assign bus.load_ready = rst_n && ((state == IDLE) || final_bit);
  assign accept         = bus.load_valid && bus.load_ready;
  assign bus.busy       = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      sreg           <= '0;
      cnt            <= '0;
      bus.sout       <= 1'b0;
      bus.sout_valid <= 1'b0;
      bus.sout_last  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par            <= 1'b0;
`endif
    end else if (accept) begin
      // Bit 0 goes straight to the output register. The rest wait in sreg.
      state          <= SHIFT;
      sreg           <= {1'b0, bus.din[WIDTH-1:1]};
      cnt            <= '0;
      bus.sout       <= bus.din[0];
      bus.sout_valid <= 1'b1;
      bus.sout_last  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par            <= ^bus.din;
`endif
    end else if (state == SHIFT) begin
      if (final_bit) begin
        state          <= IDLE;
        cnt            <= '0;
        bus.sout       <= 1'b0;
        bus.sout_valid <= 1'b0;
        bus.sout_last  <= 1'b0;
      end else begin
        cnt           <= cnt + CW'(1);
        sreg          <= {1'b0, sreg[WIDTH-1:1]};
        bus.sout_last <= (cnt == PRE_IDX);
`ifdef PISO_TX_PARITY_EN
        bus.sout      <= (cnt == PRE_IDX) ? par : sreg[0];
`else
        bus.sout      <= sreg[0];
`endif
      end
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx. Stimulus pushes the expected frame bits, and a monitor pops them.
// A behavioural SIPO on the line checks that each complete frame reassembles to the sent word.
module tb_piso_tx;
  localparam int unsigned W = 4;
`ifdef PISO_TX_PARITY_EN
  localparam int unsigned FL = W + 1;
`else
  localparam int unsigned FL = W;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  piso_tx_if #(.WIDTH(W)) bus ();
  piso_tx #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  logic [1:0]   exp_q[$];   // {bit, last}
  logic [W-1:0] word_q[$];
  logic [FL-1:0] sipo = '0;
  bit prev_last = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  function automatic void fail(string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t: got timeout/empty expected event", name, $time);
  endfunction

  function automatic void push_frame(logic [W-1:0] w);
    word_q.push_back(w);
    for (int unsigned i = 0; i < W; i++)
      exp_q.push_back({w[i], (i == FL - 1) ? 1'b1 : 1'b0});
`ifdef PISO_TX_PARITY_EN
    exp_q.push_back({^w, 1'b1});
`endif
  endfunction

  // Receiving SIPO, shifting toward bit 0.
  always @(posedge clk)
    if (bus.sout_valid) sipo <= {bus.sout, sipo[FL-1:1]};

  always @(negedge clk) begin
    logic [1:0] e;
    if (prev_last) begin
      if (word_q.size() == 0) fail("sipo_word_q_empty");
      else chk("sipo_word", 32'(sipo[W-1:0]), 32'(word_q.pop_front()));
    end
    prev_last = 1'b0;
    chk("busy_eq_valid", 32'(bus.busy), 32'(bus.sout_valid));
    if (bus.sout_valid) begin
      if (exp_q.size() == 0) fail("unexpected_bit");
      else begin
        e = exp_q.pop_front();
        chk("sout", 32'(bus.sout), 32'(e[1]));
        chk("sout_last", 32'(bus.sout_last), 32'(e[0]));
      end
      prev_last = bus.sout_last;
    end else begin
      chk("idle_sout", 32'(bus.sout), 32'd0);
      chk("idle_last", 32'(bus.sout_last), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w);
    bit ok;
    ok = 1'b0;
    for (int unsigned n = 0; n < 64; n++) begin
      if (bus.load_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) fail("wait_ready");
    bus.load_valid = 1'b1;
    bus.din = w;
    push_frame(w);
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic drain();
    for (int unsigned n = 0; n < 100; n++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    if (exp_q.size() != 0) fail("drain");
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at %0t: got no finish expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.din = '0;
    bus.load_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_ready", 32'(bus.load_ready), 32'd0);
    chk("rst_valid", 32'(bus.sout_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.load_ready), 32'd1);
    tick();

    // Single frame 1011: valid for exactly FL cycles, and ready only in the final cycle.
    send(4'b1011);
    for (int unsigned i = 0; i < FL; i++) begin
      @(negedge clk);
      chk("single_valid", 32'(bus.sout_valid), 32'd1);
      chk("single_ready", 32'(bus.load_ready), (i == FL - 1) ? 32'd1 : 32'd0);
      tick();
    end
    @(negedge clk);
    chk("single_end_valid", 32'(bus.sout_valid), 32'd0);
    chk("single_end_ready", 32'(bus.load_ready), 32'd1);
    drain();

    // Back-to-back 1011 then 0110, with load_valid held and din changed after the first accept.
    bus.load_valid = 1'b1;
    bus.din = 4'b1011;
    push_frame(4'b1011);
    tick();
    bus.din = 4'b0110;
    for (int unsigned i = 0; i < 2 * FL; i++) begin
      @(negedge clk);
      chk("b2b_valid", 32'(bus.sout_valid), 32'd1);
      chk("b2b_busy", 32'(bus.busy), 32'd1);
      chk("b2b_ready", 32'(bus.load_ready), ((i % FL) == FL - 1) ? 32'd1 : 32'd0);
      if (i == FL - 1) push_frame(4'b0110);
      tick();
      if (i == FL - 1) bus.load_valid = 1'b0;
    end
    drain();

    // A load attempt mid-frame is ignored until the final-bit window opens.
    send(4'b1011);
    tick();
    tick();
    bus.load_valid = 1'b1;
    bus.din = 4'b0000;
    for (int unsigned i = 2; i < FL; i++) begin
      @(negedge clk);
      chk("mid_ready", 32'(bus.load_ready), (i == FL - 1) ? 32'd1 : 32'd0);
      if (i == FL - 1) push_frame(4'b0000);
      tick();
    end
    bus.load_valid = 1'b0;
    drain();

    // Reset asserted during the bit 1 cycle aborts the frame.
    send(4'b1011);
    tick();
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    word_q.delete();
    @(negedge clk);
    chk("abort_valid", 32'(bus.sout_valid), 32'd0);
    chk("abort_sout", 32'(bus.sout), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_last", 32'(bus.sout_last), 32'd0);
    chk("abort_ready_in_rst", 32'(bus.load_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_after", 32'(bus.load_ready), 32'd1);
    tick();

    // Loopback over every word.
    for (int unsigned w = 0; w < 16; w++) send(W'(w));
    drain();

    if (word_q.size() != 0) fail("words_outstanding");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
